// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl
//   Turns PS/2 set-2 scancode bytes into snake steering. E0/F0 prefixes are
//   tracked by a small FSM. Arrow-key makes become turns that wait in a
//   2-entry queue, and the game engine drains one entry per move_tick.
//   The block also owns the pause flag (space make toggles it). If a prefix
//   byte is not followed by another byte in time, the FSM drops the sequence
//   and returns to IDLE.
//
// Optional feature (compile-time macro WASD_KEYS_EN):
//   When defined, the non-extended makes W/D/S/A (1D/23/1B/1C) seen in IDLE
//   steer up/right/down/left under the same acceptance rules as arrow keys.
//
// Ports
//   CLK         in   1  system clock, rising edge
//   RST         in   1  asynchronous active-high reset
//   keycode     in   8  scancode byte, valid while key_strobe=1
//   key_strobe  in   1  one-cycle pulse per received byte
//   move_tick   in   1  one-cycle pulse per snake step, pops one queued turn
//   dir         out  2  current direction: 00 up, 01 right, 10 down, 11 left
//   dir_change  out  1  one-cycle pulse when dir is loaded from the queue
//   pause       out  1  pause flag
//   q_count     out  2  number of queued turns (0..2)
//   turn_drop   out  1  one-cycle pulse when a decoded turn is rejected
//   seq_err     out  1  one-cycle pulse when a prefix sequence times out
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | waiting for a fresh scancode
// S_EXT     | E0 seen, next byte is an extended make or F0
// S_BRK     | F0 seen, next byte is a break code and is discarded
// S_EXT_BRK | E0 F0 seen, next byte is an extended break and is discarded

module snake_dir_ctrl #(
    parameter int TIMEOUT_CYC = 100000,
    parameter int CNT_W       = 17
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] keycode,
    input  logic       key_strobe,
    input  logic       move_tick,
    output logic [1:0] dir,
    output logic       dir_change,
    output logic       pause,
    output logic [1:0] q_count,
    output logic       turn_drop,
    output logic       seq_err
);

    localparam logic [7:0] KC_EXT   = 8'hE0;
    localparam logic [7:0] KC_BRK   = 8'hF0;
    localparam logic [7:0] KC_SPACE = 8'h29;
    localparam logic [7:0] KC_UP    = 8'h75;
    localparam logic [7:0] KC_RIGHT = 8'h74;
    localparam logic [7:0] KC_DOWN  = 8'h72;
    localparam logic [7:0] KC_LEFT  = 8'h6B;
`ifdef WASD_KEYS_EN
    localparam logic [7:0] KC_W     = 8'h1D;
    localparam logic [7:0] KC_D     = 8'h23;
    localparam logic [7:0] KC_S     = 8'h1B;
    localparam logic [7:0] KC_A     = 8'h1C;
`endif

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic             tmo_hit;

    logic             turn_vld;
    logic [1:0]       turn_dir;
    logic             pause_tgl;

    // q_head is the next turn to be applied, q_tail is only meaningful when
    // two turns are queued.
    logic [1:0]       q_head, q_tail;
    logic [1:0]       q_head_nxt, q_tail_nxt, q_count_nxt;

    logic             do_pop, do_push, reject;
    logic [1:0]       cnt_pp, dir_pp, head_pp, ref_dir;

    // A strobe in the terminal cycle is a valid follower, so it beats the
    // timeout.
    assign tmo_hit = (state != S_IDLE) && !key_strobe && (tmo_cnt == TMO_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        turn_vld  = 1'b0;
        turn_dir  = DIR_UP;
        pause_tgl = 1'b0;

        if (tmo_hit) begin
            state_nxt = S_IDLE;
        end else if (key_strobe) begin
            case (state)
                S_IDLE: begin
                    case (keycode)
                        KC_EXT:   state_nxt = S_EXT;
                        KC_BRK:   state_nxt = S_BRK;
                        KC_SPACE: pause_tgl = 1'b1;
`ifdef WASD_KEYS_EN
                        KC_W: begin turn_vld = 1'b1; turn_dir = DIR_UP;    end
                        KC_D: begin turn_vld = 1'b1; turn_dir = DIR_RIGHT; end
                        KC_S: begin turn_vld = 1'b1; turn_dir = DIR_DOWN;  end
                        KC_A: begin turn_vld = 1'b1; turn_dir = DIR_LEFT;  end
`endif
                        default: ;
                    endcase
                end
                S_EXT: begin
                    state_nxt = S_IDLE;
                    case (keycode)
                        KC_BRK:   state_nxt = S_EXT_BRK;
                        KC_EXT:   state_nxt = S_EXT;
                        KC_UP:    begin turn_vld = 1'b1; turn_dir = DIR_UP;    end
                        KC_RIGHT: begin turn_vld = 1'b1; turn_dir = DIR_RIGHT; end
                        KC_DOWN:  begin turn_vld = 1'b1; turn_dir = DIR_DOWN;  end
                        KC_LEFT:  begin turn_vld = 1'b1; turn_dir = DIR_LEFT;  end
                        default: ;
                    endcase
                end
                S_BRK:     state_nxt = S_IDLE;
                S_EXT_BRK: state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        if (key_strobe || (state == S_IDLE) || tmo_hit) begin
            tmo_cnt_nxt = '0;
        end else begin
            tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
    end

    // Pop is applied first. The push is then judged against the queue as it
    // looks after the pop, so a full queue that is popped in the same cycle
    // still accepts the turn.
    always_comb begin
        do_pop  = move_tick && (q_count != 2'd0) && !pause;
        cnt_pp  = do_pop ? (q_count - 2'd1) : q_count;
        dir_pp  = do_pop ? q_head : dir;
        head_pp = do_pop ? q_tail : q_head;

        case (cnt_pp)
            2'd0:    ref_dir = dir_pp;
            2'd1:    ref_dir = head_pp;
            default: ref_dir = q_tail;
        endcase

        reject  = (turn_dir == ref_dir) ||
                  (turn_dir == (ref_dir ^ 2'b10)) ||
                  (cnt_pp == 2'd2);
        do_push = turn_vld && !reject;

        q_head_nxt  = head_pp;
        q_tail_nxt  = q_tail;
        q_count_nxt = cnt_pp;
        if (do_push) begin
            if (cnt_pp == 2'd0) begin
                q_head_nxt = turn_dir;
            end else begin
                q_tail_nxt = turn_dir;
            end
            q_count_nxt = cnt_pp + 2'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dir        <= DIR_RIGHT;
            dir_change <= 1'b0;
            pause      <= 1'b0;
            q_count    <= 2'd0;
            q_head     <= DIR_UP;
            q_tail     <= DIR_UP;
            turn_drop  <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            dir        <= dir_pp;
            dir_change <= do_pop;
            pause      <= pause ^ pause_tgl;
            q_count    <= q_count_nxt;
            q_head     <= q_head_nxt;
            q_tail     <= q_tail_nxt;
            turn_drop  <= turn_vld && reject;
            seq_err    <= tmo_hit;
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
module tb_snake_dir_ctrl;

    logic       CLK;
    logic       RST;
    logic [7:0] keycode;
    logic       key_strobe;
    logic       move_tick;
    logic [1:0] dir;
    logic       dir_change;
    logic       pause;
    logic [1:0] q_count;
    logic       turn_drop;
    logic       seq_err;

    int total = 0;
    int bad   = 0;

    snake_dir_ctrl #(
        .TIMEOUT_CYC(16),
        .CNT_W      (5)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .keycode   (keycode),
        .key_strobe(key_strobe),
        .move_tick (move_tick),
        .dir       (dir),
        .dir_change(dir_change),
        .pause     (pause),
        .q_count   (q_count),
        .turn_drop (turn_drop),
        .seq_err   (seq_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change on the falling edge; results of the byte are visible at
    // the next falling edge, when the task returns.
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        keycode    = b;
        key_strobe = 1'b1;
        @(negedge CLK);
        key_strobe = 1'b0;
    endtask

    task automatic send_ext(input logic [7:0] b);
        send_byte(8'hE0);
        send_byte(b);
    endtask

    task automatic tick();
        @(negedge CLK);
        move_tick = 1'b1;
        @(negedge CLK);
        move_tick = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; keycode = 8'h00; key_strobe = 1'b0; move_tick = 1'b0;
        repeat (3) @(negedge CLK);
        total++; if (dir !== 2'b01) begin bad++; $display("FAIL reset_dir got=%b want=01", dir); end
        total++; if (q_count !== 2'd0) begin bad++; $display("FAIL reset_q got=%0d want=0", q_count); end
        total++; if ({pause, dir_change, turn_drop, seq_err} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {pause, dir_change, turn_drop, seq_err}); end
        RST = 1'b0;
        // dirty state then async reset in the middle of an E0 sequence
        send_ext(8'h75);
        send_byte(8'h29);
        send_byte(8'hE0);
        #2 RST = 1'b1;
        #1;
        total++; if ({dir, q_count, pause} !== 5'b01_00_0) begin bad++; $display("FAIL async_reset got=%b want=01000", {dir, q_count, pause}); end
        @(negedge CLK);
        RST = 1'b0;
        send_ext(8'h75);
        total++; if (q_count !== 2'd1) begin bad++; $display("FAIL post_reset_turn got=%0d want=1", q_count); end
        total++; if (turn_drop !== 1'b0) begin bad++; $display("FAIL post_reset_drop got=%b want=0", turn_drop); end
    endtask

    task automatic test_pop_and_break();
        tick();
        total++; if ({dir, q_count} !== 4'b00_00) begin bad++; $display("FAIL pop_up got=%b want=0000", {dir, q_count}); end
        total++; if (dir_change !== 1'b1) begin bad++; $display("FAIL dir_change_pulse got=%b want=1", dir_change); end
        @(negedge CLK);
        total++; if (dir_change !== 1'b0) begin bad++; $display("FAIL dir_change_width got=%b want=0", dir_change); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        total++; if ({dir, q_count, turn_drop} !== 5'b00_00_0) begin bad++; $display("FAIL ext_break got=%b want=00000", {dir, q_count, turn_drop}); end
    endtask

    task automatic test_accept_reject();
        send_ext(8'h74);
        tick();
        total++; if (dir !== 2'b01) begin bad++; $display("FAIL setup_right got=%b want=01", dir); end
        send_ext(8'h6B);
        total++; if ({turn_drop, q_count} !== 3'b1_00) begin bad++; $display("FAIL reverse_drop got=%b want=100", {turn_drop, q_count}); end
        @(negedge CLK);
        total++; if (turn_drop !== 1'b0) begin bad++; $display("FAIL drop_width got=%b want=0", turn_drop); end
        send_ext(8'h74);
        total++; if ({turn_drop, q_count} !== 3'b1_00) begin bad++; $display("FAIL same_drop got=%b want=100", {turn_drop, q_count}); end
        send_ext(8'h75);
        send_ext(8'h74);
        total++; if ({turn_drop, q_count} !== 3'b0_10) begin bad++; $display("FAIL two_queued got=%b want=010", {turn_drop, q_count}); end
        tick();
        total++; if ({dir, q_count} !== 4'b00_01) begin bad++; $display("FAIL drain1 got=%b want=0001", {dir, q_count}); end
        tick();
        total++; if ({dir, q_count} !== 4'b01_00) begin bad++; $display("FAIL drain2 got=%b want=0100", {dir, q_count}); end
        tick();
        total++; if ({dir, dir_change} !== 3'b01_0) begin bad++; $display("FAIL empty_tick got=%b want=010", {dir, dir_change}); end
    endtask

    task automatic test_back_to_back();
        send_ext(8'h75);
        tick();
        send_ext(8'h74);
        send_ext(8'h75);
        total++; if (q_count !== 2'd2) begin bad++; $display("FAIL fill got=%0d want=2", q_count); end
        send_ext(8'h6B);
        total++; if ({turn_drop, q_count} !== 3'b1_10) begin bad++; $display("FAIL full_drop got=%b want=110", {turn_drop, q_count}); end
        send_byte(8'hE0);
        @(negedge CLK);
        keycode = 8'h6B; key_strobe = 1'b1; move_tick = 1'b1;
        @(negedge CLK);
        key_strobe = 1'b0; move_tick = 1'b0;
        total++; if ({q_count, turn_drop} !== 3'b10_0) begin bad++; $display("FAIL pop_push_q got=%b want=100", {q_count, turn_drop}); end
        total++; if ({dir, dir_change} !== 3'b01_1) begin bad++; $display("FAIL pop_push_dir got=%b want=011", {dir, dir_change}); end
        tick();
        total++; if (dir !== 2'b00) begin bad++; $display("FAIL bb_drain1 got=%b want=00", dir); end
        tick();
        total++; if ({dir, q_count} !== 4'b11_00) begin bad++; $display("FAIL bb_drain2 got=%b want=1100", {dir, q_count}); end
    endtask

    task automatic test_timeout();
        int got;
        got = 0;
        send_byte(8'hE0);
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (seq_err === 1'b1) begin
                got = i;
                break;
            end
        end
        total++; if (got !== 16) begin bad++; $display("FAIL timeout_cycle got=%0d want=16", got); end
        @(negedge CLK);
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL seq_err_width got=%b want=0", seq_err); end
        send_byte(8'h75);
        total++; if ({q_count, turn_drop} !== 3'b00_0) begin bad++; $display("FAIL orphan_75 got=%b want=000", {q_count, turn_drop}); end
        // follower lands exactly in the terminal cycle
        send_byte(8'hE0);
        repeat (15) @(negedge CLK);
        keycode = 8'h75; key_strobe = 1'b1;
        @(negedge CLK);
        key_strobe = 1'b0;
        total++; if ({seq_err, q_count} !== 3'b0_01) begin bad++; $display("FAIL strobe_wins got=%b want=001", {seq_err, q_count}); end
        @(negedge CLK);
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL strobe_wins_late got=%b want=0", seq_err); end
        tick();
        total++; if (dir !== 2'b00) begin bad++; $display("FAIL strobe_wins_dir got=%b want=00", dir); end
    endtask

    task automatic test_pause_wasd();
        logic [1:0] exp_q;
        send_ext(8'h74);
        tick();
        send_byte(8'h29);
        total++; if (pause !== 1'b1) begin bad++; $display("FAIL pause_on got=%b want=1", pause); end
        send_ext(8'h72);
        total++; if (q_count !== 2'd1) begin bad++; $display("FAIL paused_push got=%0d want=1", q_count); end
        tick();
        total++; if ({dir, q_count, dir_change} !== 5'b01_01_0) begin bad++; $display("FAIL paused_tick got=%b want=01010", {dir, q_count, dir_change}); end
        send_byte(8'h29);
        total++; if (pause !== 1'b0) begin bad++; $display("FAIL pause_off got=%b want=0", pause); end
        tick();
        total++; if ({dir, dir_change} !== 3'b10_1) begin bad++; $display("FAIL unpaused_tick got=%b want=101", {dir, dir_change}); end
        send_ext(8'h74);
        tick();
`ifdef WASD_KEYS_EN
        exp_q = 2'd1;
`else
        exp_q = 2'd0;
`endif
        send_byte(8'h1D);
        total++; if (q_count !== exp_q) begin bad++; $display("FAIL wasd_w got=%0d want=%0d", q_count, exp_q); end
        send_byte(8'hF0);
        send_byte(8'h1D);
        total++; if ({q_count, turn_drop} !== {exp_q, 1'b0}) begin bad++; $display("FAIL wasd_break got=%b want=%b", {q_count, turn_drop}, {exp_q, 1'b0}); end
    endtask

    initial begin
        test_reset();
        test_pop_and_break();
        test_accept_reject();
        test_back_to_back();
        test_timeout();
        test_pause_wasd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
